pwm_capture: RTL and testbench
==============================

# pwm_capture

Input-capture block for PWM waveforms. Sits on the receive side of the multi-mode timer's PWM output, or any external PWM source, on the same divided clock. Measures the period and the high time of each complete PWM cycle in clock cycles. Reports results through a one-cycle valid strobe, a sticky capture interrupt and a sticky timeout interrupt for stuck (0 %/100 % duty or dead) inputs.

## Interface

**Parameters**
- `WIDTH`, 32: width of the counters and the measurement outputs.
- `TIMEOUT_CYCLES`, 1000: maximum counted cycles without a rising edge before a timeout. Legal range 2 .. 2^WIDTH−1.

**Ports**
- `divided_clk` input 1: block clock. The only clock.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: capture enable. Low forces IDLE.
- `pwm_in` input 1: PWM waveform to measure. May be asynchronous when `PWM_CAPTURE_SYNC_EN` is defined.
- `clear_int` input 1: clears `capture_int` and `timeout_int`.
- `period_out` output WIDTH: last measured period in cycles.
- `high_out` output WIDTH: last measured high time in cycles.
- `capture_valid` output 1: one-cycle pulse when `period_out`/`high_out` update.
- `capture_int` output 1: sticky; set with every `capture_valid`.
- `timeout_int` output 1: sticky; set on timeout.

## Operation

- **Sampled input `pwm_s`:** `pwm_in` after the optional synchronizer.
- **Edge detection:** register `pwm_prev` holds the previous `pwm_s`.
  - `rise` = `pwm_s & ~pwm_prev`.
  - `fall` = `~pwm_s & pwm_prev`.
- **Counters:** `per_cnt` and `hi_cnt`, both WIDTH bits.
- **States:**
  - **IDLE:** counters = 0. Go to ARM when `enable` = 1.
  - **ARM:** wait for `rise`. On `rise`: `per_cnt` ← 1, `hi_cnt` ← 1, go to HIGH.
  - **HIGH:** each cycle `per_cnt` +1. On `fall`: go to LOW. Otherwise `hi_cnt` +1.
  - **LOW:** each cycle `per_cnt` +1, `hi_cnt` frozen. On `rise`:
    - `period_out` ← `per_cnt`, `high_out` ← `hi_cnt`.
    - pulse `capture_valid`, set `capture_int`.
    - `per_cnt` ← 1, `hi_cnt` ← 1, go to HIGH.
  - **Timeout:** in HIGH or LOW, when `per_cnt` = `TIMEOUT_CYCLES` and no `rise` is present in that cycle:
    - set `timeout_int`, go to ARM.
    - `period_out`/`high_out` hold their previous values.
- **Overflow:** `per_cnt` and `hi_cnt` never exceed `TIMEOUT_CYCLES`, so no wrap can occur.
- **`enable` low:** state goes to IDLE next cycle and any partial measurement is discarded. Outputs and sticky flags hold.
- **Sticky flags:** `clear_int` clears both. If a set and `clear_int` occur in the same cycle, the set wins.
- **First measurement:** requires two rising edges. The first edge only arms the counters.

## Timing

- **Reset values:** `period_out` = 0, `high_out` = 0, `capture_valid` = 0, `capture_int` = 0, `timeout_int` = 0. State = IDLE, `pwm_prev` = 0, synchronizer flops = 0.
- **Reset mid-measurement:** everything returns to the reset values immediately. No capture is reported for the interrupted cycle.
- **Period:** if `pwm_s` rises in cycles t0 and t0+P, and is high for cycles t0 .. t0+H−1, then `period_out` = P and `high_out` = H.
  - Both outputs update at the clock edge ending cycle t0+P.
  - `capture_valid` is high during cycle t0+P+1 only.
- **Latency from `pwm_in` to `pwm_s`:** 2 cycles with `PWM_CAPTURE_SYNC_EN` defined, 0 without.
  - The measured P and H are unaffected; only the report time shifts.
- **Minimum measurable waveform:** H ≥ 1 and P ≥ 2 sampled cycles. Shorter pulses are invisible at the sampled rate.
- **Timeout:** `timeout_int` is visible in the cycle after `per_cnt` reaches `TIMEOUT_CYCLES`.
- **`enable` rising edge:** state moves from IDLE to ARM at the next clock. A `rise` already in that cycle is not captured.

## Configuration

- **`PWM_CAPTURE_SYNC_EN` defined:** `pwm_in` passes through a 2-flop synchronizer before the edge detector. Use this for asynchronous or external sources.
- **`PWM_CAPTURE_SYNC_EN` undefined:** `pwm_s` = `pwm_in` directly. Valid only for sources that are synchronous to `divided_clk`, such as the on-chip timer. Report latency is 2 cycles shorter.

## Test plan

1. **Basic capture:** reset, `enable` = 1, drive a synchronous PWM with period 10, high 5, for 4 periods. Expect `period_out` = 10 and `high_out` = 5, and exactly 3 `capture_valid` pulses, each 1 cycle wide. `capture_int` = 1 after the first.
2. **Duty change:** period 10, high 5, then switch to period 6, high 1. The next capture reports 6 and 1. Then period 8, high 7 reports 8 and 7.
3. **Stuck input:** `TIMEOUT_CYCLES` = 50. After one rise, hold `pwm_in` = 1. `timeout_int` sets exactly 50 counted cycles after the arming rise, and `period_out` is unchanged. Repeat with `pwm_in` held 0.
4. **Clear collision:** assert `clear_int` in the same cycle as a `capture_valid`. Expect `capture_int` to remain 1. A lone `clear_int` then clears both flags.
5. **Reset and enable mid-measurement:**
   - Assert `rst` during HIGH. All outputs become 0 immediately.
   - Separately, drop `enable` in LOW, then re-enable. The first capture occurs only after two new rises and reports a correct P/H.
6. **Synchronizer build:** with `PWM_CAPTURE_SYNC_EN` defined, drive an asynchronous PWM with period 20, high 12 (edges offset by 3 ns). Expect 20 and 12, reported 2 cycles later than in the non-sync build.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM capture block and its controller.
// master drives enable/pwm_in/clear_int; slave returns measurements and interrupts.
interface pwm_capture_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic             pwm_in;
  logic             clear_int;
  logic [WIDTH-1:0] period_out;
  logic [WIDTH-1:0] high_out;
  logic             capture_valid;
  logic             capture_int;
  logic             timeout_int;

  modport master (
    output enable, pwm_in, clear_int,
    input  period_out, high_out, capture_valid, capture_int, timeout_int
  );

  modport slave (
    input  enable, pwm_in, clear_int,
    output period_out, high_out, capture_valid, capture_int, timeout_int
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of each full PWM cycle.
// Define PWM_CAPTURE_SYNC_EN to insert a 2-flop synchronizer on pwm_in.
module pwm_capture #(
  parameter int              WIDTH          = 32,
  parameter longint unsigned TIMEOUT_CYCLES = 1000
) (
  input logic          divided_clk,
  input logic          rst,
  pwm_capture_if.slave cap
);

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q;
  logic             cap_int_q, cap_int_d;
  logic             to_int_q, to_int_d;
  logic             pwm_s, pwm_prev_q;
  logic             rise, fall;
  logic             capture, timeout;

`ifdef PWM_CAPTURE_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge divided_clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cap.pwm_in;
      sync2_q <= sync1_q;
    end
  end

  assign pwm_s = sync2_q;
`else
  assign pwm_s = cap.pwm_in;
`endif

  assign rise = pwm_s & ~pwm_prev_q;
  assign fall = ~pwm_s & pwm_prev_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    per_d   = per_q;
    hi_d    = hi_q;
    capture = 1'b0;
    timeout = 1'b0;

    unique case (state_q)
      IDLE: begin
        per_d = '0;
        hi_d  = '0;
        if (cap.enable) state_d = ARM;
      end
      ARM: begin
        if (rise) begin
          per_d   = ONE;
          hi_d    = ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (per_q == TIMEOUT_W && !rise) begin
          timeout = 1'b1;
          per_d   = '0;
          hi_d    = '0;
          state_d = ARM;
        end else begin
          per_d = per_q + ONE;
          if (fall) state_d = LOW;
          else      hi_d    = hi_q + ONE;
        end
      end
      LOW: begin
        if (rise) begin
          capture = 1'b1;
          per_d   = ONE;
          hi_d    = ONE;
          state_d = HIGH;
        end else if (per_q == TIMEOUT_W) begin
          timeout = 1'b1;
          per_d   = '0;
          hi_d    = '0;
          state_d = ARM;
        end else begin
          per_d = per_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything: the partial measurement is simply dropped.
    if (!cap.enable) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
      capture = 1'b0;
      timeout = 1'b0;
    end
  end

  assign period_d  = capture ? per_q : period_q;
  assign high_d    = capture ? hi_q  : high_q;
  // A set in the same cycle as clear_int wins.
  assign cap_int_d = capture | (cap_int_q & ~cap.clear_int);
  assign to_int_d  = timeout | (to_int_q  & ~cap.clear_int);

  always_ff @(posedge divided_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      per_q      <= '0;
      hi_q       <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      cap_int_q  <= 1'b0;
      to_int_q   <= 1'b0;
      pwm_prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the values from before the edge.
      state_q    <= state_d;
      per_q      <= per_d;
      hi_q       <= hi_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= capture;
      cap_int_q  <= cap_int_d;
      to_int_q   <= to_int_d;
      pwm_prev_q <= pwm_s;
    end
  end

  assign cap.period_out    = period_q;
  assign cap.high_out      = high_q;
  assign cap.capture_valid = valid_q;
  assign cap.capture_int   = cap_int_q;
  assign cap.timeout_int   = to_int_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: cycle-arithmetic reference model plus
// directed and randomized PWM scenarios.
module tb_pwm_capture;

  localparam int W  = 16;
  localparam int TO = 50;
`ifdef PWM_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    int p;
    int h;
  } meas_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_capture_if #(.WIDTH(W)) cap ();

  pwm_capture #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .divided_clk(clk),
    .rst        (rst),
    .cap        (cap)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int extra_skew = 0;

  // Reference model state: cycle numbers of the sampled waveform.
  bit         pwm_q[$];
  bit         m_prev, m_en_prev, have, fell;
  int         rise_c, hi_len;
  logic       exp_valid, exp_ci, exp_ti;
  logic [W-1:0] exp_per, exp_hi;

  // Observations of the DUT.
  int    strobe_bad, out_bad, pulses, to_seen_c, first_valid_c;
  meas_t log_q[$];

  task automatic tick(input bit en, input bit v, input bit clr);
    int c;
    bit vs, rise, act, set_cap, set_to;
    if (extra_skew > 0) #(extra_skew);
    cap.enable    = en;
    cap.pwm_in    = v;
    cap.clear_int = clr;
    c = cyc;
    pwm_q.push_back(v);
    vs      = (pwm_q.size() > LAT) ? pwm_q.pop_front() : 1'b0;
    rise    = vs && !m_prev;
    m_prev  = vs;
    act     = m_en_prev && en;
    set_cap = 1'b0;
    set_to  = 1'b0;
    if (!act) begin
      have = 1'b0;
    end else if (rise) begin
      if (have) begin
        set_cap = 1'b1;
        exp_per = W'(c - rise_c);
        exp_hi  = W'(hi_len);
      end
      have   = 1'b1;
      rise_c = c;
      hi_len = 1;
      fell   = 1'b0;
    end else if (have) begin
      if (c - rise_c == TO) begin
        set_to = 1'b1;
        have   = 1'b0;
      end else if (!vs) begin
        fell = 1'b1;
      end else if (!fell) begin
        hi_len++;
      end
    end
    m_en_prev = en;
    exp_valid = set_cap;
    exp_ci    = set_cap ? 1'b1 : (clr ? 1'b0 : exp_ci);
    exp_ti    = set_to  ? 1'b1 : (clr ? 1'b0 : exp_ti);

    @(posedge clk);
    #1;
    cyc++;
    if (cap.capture_valid !== exp_valid) strobe_bad++;
    if ({cap.period_out, cap.high_out, cap.capture_int, cap.timeout_int} !==
        {exp_per, exp_hi, exp_ci, exp_ti}) out_bad++;
    if (cap.capture_valid === 1'b1) begin
      meas_t m;
      m.p = int'(cap.period_out);
      m.h = int'(cap.high_out);
      log_q.push_back(m);
      pulses++;
      if (first_valid_c < 0) first_valid_c = cyc;
    end
    if (cap.timeout_int === 1'b1 && to_seen_c < 0) to_seen_c = cyc;
  endtask

  task automatic drive_period(input int p, input int h, input bit rnd_clr);
    for (int i = 0; i < p; i++) tick(1'b1, i < h, rnd_clr && ($urandom_range(7, 0) == 0));
  endtask

  task automatic hold(input int n, input bit v);
    for (int i = 0; i < n; i++) tick(1'b1, v, 1'b0);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    cap.enable    = 1'b0;
    cap.pwm_in    = 1'b0;
    cap.clear_int = 1'b0;
    pwm_q.delete();
    m_prev = 0; m_en_prev = 0; have = 0; fell = 0; rise_c = 0; hi_len = 0;
    exp_valid = 0; exp_ci = 0; exp_ti = 0; exp_per = '0; exp_hi = '0;
    strobe_bad = 0; out_bad = 0; pulses = 0; to_seen_c = -1; first_valid_c = -1;
    log_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cap.period_out !== '0) begin errors++; $display("FAIL reset_period: got %0d want 0", cap.period_out); end
    checks++; if (cap.high_out !== '0) begin errors++; $display("FAIL reset_high: got %0d want 0", cap.high_out); end
    checks++; if (cap.capture_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cap.capture_valid); end
    checks++; if (cap.capture_int !== 1'b0) begin errors++; $display("FAIL reset_capint: got %b want 0", cap.capture_int); end
    checks++; if (cap.timeout_int !== 1'b0) begin errors++; $display("FAIL reset_toint: got %b want 0", cap.timeout_int); end
  endtask

  task automatic test_basic();
    do_reset();
    hold(3, 1'b0);
    repeat (4) drive_period(10, 5, 1'b0);
    hold(4, 1'b0);
    checks++; if (pulses !== 3) begin errors++; $display("FAIL basic_pulses: got %0d want 3", pulses); end
    checks++; if (strobe_bad !== 0) begin errors++; $display("FAIL basic_strobe: %0d bad cycles want 0", strobe_bad); end
    checks++; if (out_bad !== 0) begin errors++; $display("FAIL basic_outputs: %0d bad cycles want 0", out_bad); end
    checks++; if (cap.period_out !== W'(10)) begin errors++; $display("FAIL basic_period: got %0d want 10", cap.period_out); end
    checks++; if (cap.high_out !== W'(5)) begin errors++; $display("FAIL basic_high: got %0d want 5", cap.high_out); end
    checks++; if (cap.capture_int !== 1'b1) begin errors++; $display("FAIL basic_capint: got %b want 1", cap.capture_int); end
  endtask

  task automatic test_duty_change();
    int want_p[3] = '{10, 6, 8};
    int want_h[3] = '{5, 1, 7};
    do_reset();
    hold(2, 1'b0);
    drive_period(10, 5, 1'b0);
    drive_period(6, 1, 1'b0);
    drive_period(8, 7, 1'b0);
    drive_period(2, 1, 1'b0);
    hold(3, 1'b0);
    checks++; if (log_q.size() !== 3) begin errors++; $display("FAIL duty_count: got %0d want 3", log_q.size()); end
    for (int k = 0; k < 3 && k < log_q.size(); k++) begin
      checks++; if (log_q[k].p !== want_p[k]) begin errors++; $display("FAIL duty_period[%0d]: got %0d want %0d", k, log_q[k].p, want_p[k]); end
      checks++; if (log_q[k].h !== want_h[k]) begin errors++; $display("FAIL duty_high[%0d]: got %0d want %0d", k, log_q[k].h, want_h[k]); end
    end
    checks++; if (out_bad !== 0) begin errors++; $display("FAIL duty_outputs: %0d bad cycles want 0", out_bad); end
  endtask

  task automatic test_timeout();
    int r;
    do_reset();
    hold(2, 1'b0);
    drive_period(10, 5, 1'b0);
    r = cyc;
    hold(60, 1'b1);
    checks++; if (to_seen_c !== r + LAT + TO + 1) begin errors++; $display("FAIL to_high_time: got cycle %0d want %0d", to_seen_c, r + LAT + TO + 1); end
    checks++; if (cap.period_out !== W'(10)) begin errors++; $display("FAIL to_high_period: got %0d want 10", cap.period_out); end
    checks++; if (cap.high_out !== W'(5)) begin errors++; $display("FAIL to_high_high: got %0d want 5", cap.high_out); end
    tick(1'b1, 1'b1, 1'b1);
    checks++; if (cap.timeout_int !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", cap.timeout_int); end
    to_seen_c = -1;
    tick(1'b1, 1'b0, 1'b0);
    r = cyc;
    hold(3, 1'b1);
    hold(60, 1'b0);
    checks++; if (to_seen_c !== r + LAT + TO + 1) begin errors++; $display("FAIL to_low_time: got cycle %0d want %0d", to_seen_c, r + LAT + TO + 1); end
    checks++; if (cap.period_out !== W'(10)) begin errors++; $display("FAIL to_low_period: got %0d want 10", cap.period_out); end
    checks++; if (out_bad !== 0) begin errors++; $display("FAIL to_outputs: %0d bad cycles want 0", out_bad); end
  endtask

  task automatic test_clear_collision();
    do_reset();
    hold(2, 1'b0);
    drive_period(5, 2, 1'b0);
    hold(55, 1'b0);
    checks++; if (cap.timeout_int !== 1'b1) begin errors++; $display("FAIL clr_pre_to: got %b want 1", cap.timeout_int); end
    drive_period(10, 5, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, i < 5, i == LAT);
    checks++; if (cap.capture_int !== 1'b1) begin errors++; $display("FAIL clr_collide_capint: got %b want 1", cap.capture_int); end
    checks++; if (cap.timeout_int !== 1'b0) begin errors++; $display("FAIL clr_collide_toint: got %b want 0", cap.timeout_int); end
    checks++; if (cap.period_out !== W'(10)) begin errors++; $display("FAIL clr_collide_period: got %0d want 10", cap.period_out); end
    hold(50, 1'b0);
    checks++; if (cap.timeout_int !== 1'b1) begin errors++; $display("FAIL clr_both_set_to: got %b want 1", cap.timeout_int); end
    tick(1'b1, 1'b0, 1'b1);
    checks++; if (cap.capture_int !== 1'b0) begin errors++; $display("FAIL clr_lone_capint: got %b want 0", cap.capture_int); end
    checks++; if (cap.timeout_int !== 1'b0) begin errors++; $display("FAIL clr_lone_toint: got %b want 0", cap.timeout_int); end
    checks++; if (out_bad !== 0) begin errors++; $display("FAIL clr_outputs: %0d bad cycles want 0", out_bad); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hold(2, 1'b0);
    drive_period(10, 5, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    checks++; if (cap.period_out !== W'(10)) begin errors++; $display("FAIL rmid_pre_period: got %0d want 10", cap.period_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (cap.period_out !== '0) begin errors++; $display("FAIL rmid_period: got %0d want 0", cap.period_out); end
    checks++; if (cap.high_out !== '0) begin errors++; $display("FAIL rmid_high: got %0d want 0", cap.high_out); end
    checks++; if (cap.capture_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", cap.capture_valid); end
    checks++; if (cap.capture_int !== 1'b0) begin errors++; $display("FAIL rmid_capint: got %b want 0", cap.capture_int); end
    checks++; if (cap.timeout_int !== 1'b0) begin errors++; $display("FAIL rmid_toint: got %b want 0", cap.timeout_int); end
    do_reset();
    hold(2, 1'b0);
    drive_period(4, 2, 1'b0);
    hold(5, 1'b0);
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rmid_no_capture: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_enable_toggle();
    do_reset();
    hold(2, 1'b0);
    drive_period(10, 5, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, i < 5, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    hold(2, 1'b0);
    drive_period(7, 3, 1'b0);
    drive_period(7, 3, 1'b0);
    hold(3, 1'b0);
    checks++; if (pulses !== 2) begin errors++; $display("FAIL en_pulses: got %0d want 2", pulses); end
    if (log_q.size() == 2) begin
      checks++; if (log_q[1].p !== 7) begin errors++; $display("FAIL en_period: got %0d want 7", log_q[1].p); end
      checks++; if (log_q[1].h !== 3) begin errors++; $display("FAIL en_high: got %0d want 3", log_q[1].h); end
    end
    checks++; if (out_bad !== 0) begin errors++; $display("FAIL en_outputs: %0d bad cycles want 0", out_bad); end
  endtask

  task automatic test_random();
    meas_t gen[$];
    do_reset();
    hold(2, 1'b0);
    for (int k = 0; k < 12; k++) begin
      meas_t m;
      m.p = int'($urandom_range(30, 2));
      m.h = int'($urandom_range(m.p - 1, 1));
      gen.push_back(m);
      drive_period(m.p, m.h, 1'b1);
    end
    drive_period(3, 1, 1'b0);
    hold(3, 1'b0);
    checks++; if (log_q.size() !== gen.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", log_q.size(), gen.size()); end
    for (int k = 0; k < gen.size() && k < log_q.size(); k++) begin
      checks++; if (log_q[k].p !== gen[k].p) begin errors++; $display("FAIL rnd_period[%0d]: got %0d want %0d", k, log_q[k].p, gen[k].p); end
      checks++; if (log_q[k].h !== gen[k].h) begin errors++; $display("FAIL rnd_high[%0d]: got %0d want %0d", k, log_q[k].h, gen[k].h); end
    end
    checks++; if (strobe_bad !== 0) begin errors++; $display("FAIL rnd_strobe: %0d bad cycles want 0", strobe_bad); end
    checks++; if (out_bad !== 0) begin errors++; $display("FAIL rnd_outputs: %0d bad cycles want 0", out_bad); end
  endtask

  task automatic test_back_to_back_skewed();
    int r;
    do_reset();
    extra_skew = 2;
    hold(2, 1'b0);
    r = cyc;
    repeat (3) drive_period(20, 12, 1'b0);
    hold(3, 1'b0);
    extra_skew = 0;
    checks++; if (first_valid_c !== r + 20 + LAT + 1) begin errors++; $display("FAIL skew_latency: got cycle %0d want %0d", first_valid_c, r + 20 + LAT + 1); end
    checks++; if (log_q.size() !== 2) begin errors++; $display("FAIL skew_count: got %0d want 2", log_q.size()); end
    for (int k = 0; k < 2 && k < log_q.size(); k++) begin
      checks++; if (log_q[k].p !== 20) begin errors++; $display("FAIL skew_period[%0d]: got %0d want 20", k, log_q[k].p); end
      checks++; if (log_q[k].h !== 12) begin errors++; $display("FAIL skew_high[%0d]: got %0d want 12", k, log_q[k].h); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_duty_change();
    test_timeout();
    test_clear_collision();
    test_reset_mid();
    test_enable_toggle();
    test_random();
    test_back_to_back_skewed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
